// File: rtl/sdram_rr_arbiter_if.sv
// rtl/sdram_rr_arbiter_if.sv - Avalon-MM style command/response link (master side drives the command)
interface sdram_rr_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int BE_W   = 2
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_rr_arbiter.sv
// rtl/sdram_rr_arbiter.sv - two-master round-robin arbiter onto one SDRAM controller port
// Commands are serialised through a registered grant; read responses are steered by an in-order ID FIFO.
module sdram_rr_arbiter #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 16,
  parameter int BE_W     = 2,
  parameter int MAX_PEND = 8
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  sdram_rr_arbiter_if.slave   m0,
  sdram_rr_arbiter_if.slave   m1,
  sdram_rr_arbiter_if.master  s,
  output logic                err_rdv
);
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam logic [PTR_W:0] FULL_CNT = MAX_PEND[PTR_W:0];

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rr_ptr, w_rr_ptr_nxt;
  logic [MAX_PEND-1:0] r_id;
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic                r_err_rdv;

  logic              w_req0, w_req1, w_own, w_sel;
  logic              w_m_read, w_m_write;
  logic [ADDR_W-1:0] w_m_address;
  logic [DATA_W-1:0] w_m_writedata;
  logic [BE_W-1:0]   w_m_byteenable;
  logic              w_fifo_full, w_fifo_empty, w_read_ok;
  logic              w_s_read, w_s_write, w_accept, w_push, w_pop, w_head;
  logic              w_wait_own, w_rdv0, w_rdv1;

  assign w_req0 = m0.read | m0.write;
  assign w_req1 = m1.read | m1.write;
  assign w_own  = (r_state != IDLE);
  assign w_sel  = (r_state == OWN1);

  assign w_m_read       = w_sel ? m1.read       : m0.read;
  assign w_m_write      = w_sel ? m1.write      : m0.write;
  assign w_m_address    = w_sel ? m1.address    : m0.address;
  assign w_m_writedata  = w_sel ? m1.writedata  : m0.writedata;
  assign w_m_byteenable = w_sel ? m1.byteenable : m0.byteenable;

  assign w_fifo_full  = (r_count == FULL_CNT);
  assign w_fifo_empty = (r_count == '0);
  // A full ID FIFO only holds back reads; the owner keeps the grant until its read fits.
  assign w_read_ok    = !w_m_read | !w_fifo_full;
  assign w_s_read     = w_own & w_m_read & w_read_ok;
  assign w_s_write    = w_own & w_m_write;
  assign w_accept     = (w_s_read | w_s_write) & !s.waitrequest;
  assign w_push       = w_accept & w_s_read;
  assign w_pop        = s.readdatavalid & !w_fifo_empty;
  assign w_head       = r_id[r_rd_ptr];

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_req0 & w_req1)  w_state_nxt = r_rr_ptr ? OWN1 : OWN0;
        else if (w_req0)      w_state_nxt = OWN0;
        else if (w_req1)      w_state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (w_accept) begin
          w_state_nxt  = IDLE;
          w_rr_ptr_nxt = ~w_sel;
        end else if (!(w_m_read | w_m_write)) begin
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign s.address    = w_own ? w_m_address    : '0;
  assign s.writedata  = w_own ? w_m_writedata  : '0;
  assign s.byteenable = w_own ? w_m_byteenable : '0;
  assign s.read       = w_s_read;
  assign s.write      = w_s_write;

  assign w_wait_own     = s.waitrequest | !w_read_ok;
  assign m0.waitrequest = (r_state == OWN0) ? w_wait_own : 1'b1;
  assign m1.waitrequest = (r_state == OWN1) ? w_wait_own : 1'b1;

  assign w_rdv0           = w_pop & !w_head;
  assign w_rdv1           = w_pop & w_head;
  assign m0.readdatavalid = w_rdv0;
  assign m1.readdatavalid = w_rdv1;
  assign m0.readdata      = w_rdv0 ? s.readdata : '0;
  assign m1.readdata      = w_rdv1 ? s.readdata : '0;
  assign err_rdv          = r_err_rdv;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= 1'b0;
      r_id      <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_rdv <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      if (w_push) begin
        r_id[r_wr_ptr] <= w_sel;
        r_wr_ptr       <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s.readdatavalid & w_fifo_empty) r_err_rdv <= 1'b1;
    end
  end
endmodule
